// File: rtl/orv64_amo_seq.sv
// orv64_amo_seq: runs one RISC-V AMO (.W/.D) on the single L1D$ port as a
// locked load, an ALU step and a store/unlock. The original memory value goes
// back to MA, which completes the AMO.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   req_*             AMO request from EX (op, width, address, rs2 operand)
//   kill              pipeline flush; only honoured before the locked load is accepted
//   dc_req_*          request to the L1D$ (locked load, then store/unlock)
//   dc_resp_*         L1D$ response (data, access/page fault)
//   done_*            result to MA (old value, misaligned, D$ exception)
//   busy              a sequence is in flight (state != IDLE)
module orv64_amo_seq #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 39
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic              req_is_word,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_src,
    input  logic              kill,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic              dc_req_is_store,
    output logic [ADDR_W-1:0] dc_req_addr,
    output logic [XLEN-1:0]   dc_req_wdata,
    output logic [7:0]        dc_req_mask,
    input  logic              dc_resp_valid,
    input  logic [XLEN-1:0]   dc_resp_rdata,
    input  logic              dc_resp_excp,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [XLEN-1:0]   done_rdata,
    output logic              done_misaligned,
    output logic              done_dc_excp,
    output logic              busy
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = 8;

    localparam logic [3:0] OP_SWAP = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_MIN  = 4'd5;
    localparam logic [3:0] OP_MAX  = 4'd6;
    localparam logic [3:0] OP_MINU = 4'd7;
    localparam logic [3:0] OP_MAXU = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_REQ,
        S_LD_WAIT,
        S_ST_REQ,
        S_ST_WAIT,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [3:0]          op_q;
    logic                is_word_q;
    logic                lane_hi_q;
    logic [XLEN-1:0]     src_q;
    logic [XLEN-1:0]     old_q;

    logic                req_ready_q;
    logic                dc_req_valid_q;
    logic                dc_req_is_store_q;
    logic [ADDR_W-1:0]   dc_req_addr_q;
    logic [XLEN-1:0]     dc_req_wdata_q;
    logic [MASK_W-1:0]   dc_req_mask_q;
    logic                done_valid_q;
    logic [XLEN-1:0]     done_rdata_q;
    logic                done_misaligned_q;
    logic                done_dc_excp_q;
    logic                busy_q;

    // AMO ALU. For .W only the low 32 bits of the result are meaningful;
    // compares run on 32-bit operands extended to XLEN (sign or zero).
    // Ties keep the memory value.
    function automatic logic [XLEN-1:0] amo_alu(
        input logic [3:0]      op,
        input logic            is_word,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] src
    );
        logic [XLEN-1:0] a_s;
        logic [XLEN-1:0] b_s;
        logic [XLEN-1:0] a_u;
        logic [XLEN-1:0] b_u;
        logic [XLEN-1:0] res;
        logic            a_lt_b_s;
        logic            b_lt_a_s;
        logic            a_lt_b_u;
        logic            b_lt_a_u;
        if (is_word) begin
            a_s = {{(XLEN-WORD_W){mem[WORD_W-1]}}, mem[WORD_W-1:0]};
            b_s = {{(XLEN-WORD_W){src[WORD_W-1]}}, src[WORD_W-1:0]};
            a_u = {{(XLEN-WORD_W){1'b0}}, mem[WORD_W-1:0]};
            b_u = {{(XLEN-WORD_W){1'b0}}, src[WORD_W-1:0]};
        end else begin
            a_s = mem;
            b_s = src;
            a_u = mem;
            b_u = src;
        end
        a_lt_b_s = $signed(a_s) < $signed(b_s);
        b_lt_a_s = $signed(b_s) < $signed(a_s);
        a_lt_b_u = a_u < b_u;
        b_lt_a_u = b_u < a_u;
        case (op)
            OP_ADD:  res = mem + src;
            OP_XOR:  res = mem ^ src;
            OP_AND:  res = mem & src;
            OP_OR:   res = mem | src;
            OP_MIN:  res = b_lt_a_s ? src : mem;
            OP_MAX:  res = a_lt_b_s ? src : mem;
            OP_MINU: res = b_lt_a_u ? src : mem;
            OP_MAXU: res = a_lt_b_u ? src : mem;
            OP_SWAP: res = src;
            default: res = src;    // reserved encodings behave as SWAP
        endcase
        return res;
    endfunction

    // Request alignment check (.W needs 4-byte, .D needs 8-byte alignment).
    logic req_misaligned_c;
    assign req_misaligned_c = req_is_word ? (req_addr[1:0] != 2'b00)
                                          : (req_addr[2:0] != 3'b000);

    // Old value as seen by the core: selected 32-bit lane sign-extended for .W.
    logic [WORD_W-1:0] lane_c;
    logic [XLEN-1:0]   old_c;
    logic [XLEN-1:0]   new_c;
    logic [XLEN-1:0]   st_wdata_c;
    logic [MASK_W-1:0] st_mask_c;

    assign lane_c     = lane_hi_q ? dc_resp_rdata[2*WORD_W-1:WORD_W] : dc_resp_rdata[WORD_W-1:0];
    assign old_c      = is_word_q ? {{(XLEN-WORD_W){lane_c[WORD_W-1]}}, lane_c} : dc_resp_rdata;
    assign new_c      = amo_alu(op_q, is_word_q, old_c, src_q);
    // .W stores replicate the word into both lanes; the mask picks the lane.
    assign st_wdata_c = is_word_q ? XLEN'({2{new_c[WORD_W-1:0]}}) : new_c;
    assign st_mask_c  = is_word_q ? (lane_hi_q ? 8'hF0 : 8'h0F) : 8'hFF;

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            op_q              <= 4'd0;
            is_word_q         <= 1'b0;
            lane_hi_q         <= 1'b0;
            src_q             <= '0;
            old_q             <= '0;
            req_ready_q       <= 1'b1;
            dc_req_valid_q    <= 1'b0;
            dc_req_is_store_q <= 1'b0;
            dc_req_addr_q     <= '0;
            dc_req_wdata_q    <= '0;
            dc_req_mask_q     <= '0;
            done_valid_q      <= 1'b0;
            done_rdata_q      <= '0;
            done_misaligned_q <= 1'b0;
            done_dc_excp_q    <= 1'b0;
            busy_q            <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        is_word_q   <= req_is_word;
                        lane_hi_q   <= req_addr[2];
                        src_q       <= req_src;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_misaligned_c) begin
                            state_q           <= S_DONE;
                            done_valid_q      <= 1'b1;
                            done_misaligned_q <= 1'b1;
                            done_rdata_q      <= '0;
                        end else begin
                            state_q           <= S_LD_REQ;
                            dc_req_valid_q    <= 1'b1;
                            dc_req_is_store_q <= 1'b0;
                            dc_req_addr_q     <= {req_addr[ADDR_W-1:3], 3'b000};
                            dc_req_wdata_q    <= '0;
                            dc_req_mask_q     <= 8'hFF;
                        end
                    end
                end

                // Acceptance wins over a simultaneous kill: once the locked
                // load is taken, the sequence must reach the store/unlock.
                S_LD_REQ: begin
                    if (dc_req_ready) begin
                        state_q        <= S_LD_WAIT;
                        dc_req_valid_q <= 1'b0;
                    end else if (kill) begin
                        state_q        <= S_IDLE;
                        dc_req_valid_q <= 1'b0;
                        dc_req_addr_q  <= '0;
                        dc_req_mask_q  <= '0;
                        req_ready_q    <= 1'b1;
                        busy_q         <= 1'b0;
                    end
                end

                S_LD_WAIT: begin
                    if (dc_resp_valid) begin
                        old_q <= old_c;
                        if (dc_resp_excp) begin
                            state_q        <= S_DONE;
                            done_valid_q   <= 1'b1;
                            done_dc_excp_q <= 1'b1;
                            done_rdata_q   <= old_c;
                        end else begin
                            state_q           <= S_ST_REQ;
                            dc_req_valid_q    <= 1'b1;
                            dc_req_is_store_q <= 1'b1;
                            dc_req_wdata_q    <= st_wdata_c;
                            dc_req_mask_q     <= st_mask_c;
                        end
                    end
                end

                S_ST_REQ: begin
                    if (dc_req_ready) begin
                        state_q        <= S_ST_WAIT;
                        dc_req_valid_q <= 1'b0;
                    end
                end

                S_ST_WAIT: begin
                    if (dc_resp_valid) begin
                        state_q        <= S_DONE;
                        done_valid_q   <= 1'b1;
                        done_dc_excp_q <= dc_resp_excp;
                        done_rdata_q   <= old_q;
                    end
                end

                // Hold the result until MA takes it, then return to the
                // all-zero idle output state.
                S_DONE: begin
                    if (done_ready) begin
                        state_q           <= S_IDLE;
                        req_ready_q       <= 1'b1;
                        busy_q            <= 1'b0;
                        done_valid_q      <= 1'b0;
                        done_rdata_q      <= '0;
                        done_misaligned_q <= 1'b0;
                        done_dc_excp_q    <= 1'b0;
                        dc_req_is_store_q <= 1'b0;
                        dc_req_addr_q     <= '0;
                        dc_req_wdata_q    <= '0;
                        dc_req_mask_q     <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign dc_req_valid    = dc_req_valid_q;
    assign dc_req_is_store = dc_req_is_store_q;
    assign dc_req_addr     = dc_req_addr_q;
    assign dc_req_wdata    = dc_req_wdata_q;
    assign dc_req_mask     = dc_req_mask_q;
    assign done_valid      = done_valid_q;
    assign done_rdata      = done_rdata_q;
    assign done_misaligned = done_misaligned_q;
    assign done_dc_excp    = done_dc_excp_q;
    assign busy            = busy_q;

    // A D$ response is only legal while a request is outstanding.
    resp_only_when_waiting_a : assert property (
        @(posedge clk) disable iff (rst)
        dc_resp_valid |-> (state_q == S_LD_WAIT || state_q == S_ST_WAIT)
    ) else $error("orv64_amo_seq: dc_resp_valid outside LD_WAIT/ST_WAIT");

endmodule

// File: tb/tb_orv64_amo_seq.sv
// Bench for orv64_amo_seq: vector table driven through a small D$ model,
// expected results queued on request and compared when done_valid handshakes.
module tb_orv64_amo_seq;

    localparam logic [3:0] SWAP = 4'd0;
    localparam logic [3:0] ADD  = 4'd1;
    localparam logic [3:0] XOR_ = 4'd2;
    localparam logic [3:0] AND_ = 4'd3;
    localparam logic [3:0] OR_  = 4'd4;
    localparam logic [3:0] MIN  = 4'd5;
    localparam logic [3:0] MAX  = 4'd6;
    localparam logic [3:0] MINU = 4'd7;
    localparam logic [3:0] MAXU = 4'd8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_is_word;
    logic [38:0] req_addr;
    logic [63:0] req_src;
    logic        kill;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic        dc_req_is_store;
    logic [38:0] dc_req_addr;
    logic [63:0] dc_req_wdata;
    logic [7:0]  dc_req_mask;
    logic        dc_resp_valid;
    logic [63:0] dc_resp_rdata;
    logic        dc_resp_excp;
    logic        done_valid;
    logic        done_ready;
    logic [63:0] done_rdata;
    logic        done_misaligned;
    logic        done_dc_excp;
    logic        busy;

    orv64_amo_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_is_word(req_is_word), .req_addr(req_addr), .req_src(req_src),
        .kill(kill),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_is_store(dc_req_is_store), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_mask(dc_req_mask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
        .dc_resp_excp(dc_resp_excp),
        .done_valid(done_valid), .done_ready(done_ready), .done_rdata(done_rdata),
        .done_misaligned(done_misaligned), .done_dc_excp(done_dc_excp),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        w;
        logic [38:0] addr;
        logic [63:0] src;
        logic [63:0] mem;
        logic        ld_excp;
        logic        st_excp;
        logic        kill;
        int          stall;
        int          hold;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_mask;
        logic [63:0] exp_rdata;
        logic        chk_rd;
        logic        exp_mis;
        int          exp_lat;
    } vec_t;

    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_ld = 0;
    int   n_st = 0;
    int   stall_cnt = 0;
    int   hold_cnt = 0;
    logic acc_pend = 1'b0;
    logic acc_store = 1'b0;
    logic no_st_resp = 1'b0;
    logic ld_seen = 1'b0;
    logic done_seen = 1'b0;
    logic busy_txn = 1'b0;
    logic manual_kill = 1'b0;
    logic want_req = 1'b0;
    logic txn_done = 1'b0;
    vec_t want_v;
    vec_t cur;
    vec_t sb[$];
    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic w, input logic [38:0] a,
                                input logic [63:0] src, input logic [63:0] mem,
                                input logic [63:0] wd, input logic [7:0] m,
                                input logic [63:0] rd, input logic mis, input int lat);
        vec_t v;
        v.op = op; v.w = w; v.addr = a; v.src = src; v.mem = mem;
        v.ld_excp = 1'b0; v.st_excp = 1'b0; v.kill = 1'b0; v.stall = 0; v.hold = 0;
        v.exp_wdata = wd; v.exp_mask = m; v.exp_rdata = rd; v.chk_rd = 1'b1;
        v.exp_mis = mis; v.exp_lat = lat;
        return v;
    endfunction

    // One cycle: D$ model, done monitor and request driver, all at the negedge.
    task automatic tick();
        vec_t e;
        @(negedge clk);
        cyc++;
        dc_resp_valid = 1'b0;
        dc_resp_excp  = 1'b0;
        dc_resp_rdata = 64'h0;
        if (acc_pend) begin
            acc_pend = 1'b0;
            if (!(acc_store && no_st_resp)) begin
                dc_resp_valid = 1'b1;
                dc_resp_rdata = cur.mem;
                dc_resp_excp  = acc_store ? cur.st_excp : cur.ld_excp;
            end
        end
        dc_req_ready = 1'b0;
        if (dc_req_valid) begin
            if (stall_cnt > 0) begin
                stall_cnt--;
            end else begin
                dc_req_ready = 1'b1;
                acc_pend     = 1'b1;
                acc_store    = dc_req_is_store;
                if (dc_req_is_store) begin
                    n_st++;
                    chk("st_addr", 64'(dc_req_addr), 64'({cur.addr[38:3], 3'b000}));
                    chk("st_wdata", dc_req_wdata, cur.exp_wdata);
                    chk("st_mask", 64'(dc_req_mask), 64'(cur.exp_mask));
                end else begin
                    n_ld++;
                    ld_seen = 1'b1;
                    chk("ld_addr", 64'(dc_req_addr), 64'({cur.addr[38:3], 3'b000}));
                    chk("ld_mask", 64'(dc_req_mask), 64'(8'hFF));
                end
            end
        end
        kill = manual_kill || (busy_txn && cur.kill && ld_seen);
        done_ready = 1'b1;
        if (done_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(done_valid), 64'(1'b0));
            end else begin
                if (!done_seen) begin
                    done_seen = 1'b1;
                    if (cur.exp_lat != 0) chk("latency", 64'(cyc - acc_cyc), 64'(cur.exp_lat));
                end
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    done_ready = 1'b0;
                    if (cur.chk_rd) chk("hold_rdata", done_rdata, cur.exp_rdata);
                    else chk("hold_excp", 64'(done_dc_excp), 64'(1'b1));
                end else begin
                    e = sb.pop_front();
                    if (e.chk_rd) chk("done_rdata", done_rdata, e.exp_rdata);
                    chk("done_mis", 64'(done_misaligned), 64'(e.exp_mis));
                    chk("done_excp", 64'(done_dc_excp), 64'(!e.exp_mis && (e.ld_excp || e.st_excp)));
                    chk("done_busy", 64'(busy), 64'(1'b1));
                    chk("n_loads", 64'(n_ld), 64'(!e.exp_mis));
                    chk("n_stores", 64'(n_st), 64'(!e.exp_mis && !e.ld_excp));
                    busy_txn = 1'b0;
                    txn_done = 1'b1;
                end
            end
        end
        req_valid = 1'b0;
        if (want_req && req_ready) begin
            req_valid   = 1'b1;
            req_op      = want_v.op;
            req_is_word = want_v.w;
            req_addr    = want_v.addr;
            req_src     = want_v.src;
            want_req    = 1'b0;
            sb.push_back(want_v);
            cur       = want_v;
            n_ld      = 0;
            n_st      = 0;
            ld_seen   = 1'b0;
            done_seen = 1'b0;
            stall_cnt = want_v.stall;
            hold_cnt  = want_v.hold;
            acc_cyc   = cyc;
            busy_txn  = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        sb.delete();
        want_req = 1'b0; acc_pend = 1'b0; busy_txn = 1'b0; manual_kill = 1'b0;
        no_st_resp = 1'b0; stall_cnt = 0; hold_cnt = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        want_v   = v;
        want_req = 1'b1;
        txn_done = 1'b0;
        for (int i = 0; i < 80 && !txn_done; i++) tick();
        if (!txn_done) begin
            chk("timeout", 64'(txn_done), 64'(1'b1));
            pulse_reset();
        end
    endtask

    initial begin
        vec_t v;
        logic found;
        rst = 1'b1;
        req_valid = 1'b0; req_op = 4'd0; req_is_word = 1'b0; req_addr = '0; req_src = '0;
        kill = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_rdata = '0;
        dc_resp_excp = 1'b0; done_ready = 1'b1;
        cur = mk(SWAP, 1'b0, 39'h0, 64'h0, 64'h0, 64'h0, 8'h0, 64'h0, 1'b0, 0);

        // Reset state
        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 64'(1'b1));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_dc_valid", 64'(dc_req_valid), 64'(1'b0));
        chk("rst_done_valid", 64'(done_valid), 64'(1'b0));
        rst = 1'b0;
        tick();

        // op, w, addr, src, mem, store wdata, store mask, done_rdata, misaligned, latency
        vt.push_back(mk(ADD,  1'b0, 39'h1000, 64'h3, 64'h5, 64'h8, 8'hFF, 64'h5, 1'b0, 5));
        vt.push_back(mk(MIN,  1'b1, 39'h1004, 64'h1, 64'h8000_0000_1234_5678,
                        64'h8000_0000_8000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0000, 1'b0, 5));
        vt.push_back(mk(MINU, 1'b1, 39'h1004, 64'h1, 64'h8000_0000_1234_5678,
                        64'h0000_0001_0000_0001, 8'hF0, 64'hFFFF_FFFF_8000_0000, 1'b0, 5));
        vt.push_back(mk(SWAP, 1'b1, 39'h1002, 64'h77, 64'h0, 64'h0, 8'h0, 64'h0, 1'b1, 1));
        v = mk(OR_, 1'b0, 39'h2000, 64'h1, 64'h2, 64'h3, 8'hFF, 64'h0, 1'b0, 3);
        v.ld_excp = 1'b1; v.chk_rd = 1'b0;
        vt.push_back(v);
        v = mk(XOR_, 1'b0, 39'h2008, 64'h0FF0, 64'hF0F0, 64'hFF00, 8'hFF, 64'hF0F0, 1'b0, 5);
        v.st_excp = 1'b1;
        vt.push_back(v);
        vt.push_back(mk(MAX,  1'b0, 39'h2010, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE,
                        64'h3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5));
        vt.push_back(mk(MAXU, 1'b0, 39'h2018, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE,
                        64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5));
        vt.push_back(mk(ADD,  1'b1, 39'h3000, 64'hDEAD_BEEF_0000_0002, 64'h1111_1111_FFFF_FFFF,
                        64'h0000_0001_0000_0001, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5));
        vt.push_back(mk(AND_, 1'b1, 39'h3004, 64'h00FF_00FF, 64'h0F0F_0F0F_0000_0000,
                        64'h000F_000F_000F_000F, 8'hF0, 64'h0000_0000_0F0F_0F0F, 1'b0, 5));
        vt.push_back(mk(MAX,  1'b1, 39'h3008, 64'h1234_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF,
                        64'h7FFF_FFFF_7FFF_FFFF, 8'h0F, 64'h0000_0000_7FFF_FFFF, 1'b0, 5));
        vt.push_back(mk(4'd12, 1'b0, 39'h6000, 64'h5555_6666_7777_8888, 64'hAAAA,
                        64'h5555_6666_7777_8888, 8'hFF, 64'hAAAA, 1'b0, 5));
        v = mk(MIN, 1'b0, 39'h6008, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5,
               64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h5, 1'b0, 5);
        v.kill = 1'b1;   // kill from load acceptance onwards must be ignored
        vt.push_back(v);
        v = mk(SWAP, 1'b0, 39'h100C, 64'h1, 64'h0, 64'h0, 8'h0, 64'h0, 1'b1, 1);
        v.hold = 4;
        vt.push_back(v);
        v = mk(MINU, 1'b0, 39'h7000, 64'h9, 64'h7, 64'h7, 8'hFF, 64'h7, 1'b0, 8);
        v.stall = 3; v.hold = 4;
        vt.push_back(v);
        vt.push_back(mk(MAXU, 1'b1, 39'h1000, 64'h10, 64'h0000_0000_FFFF_FFF0,
                        64'hFFFF_FFF0_FFFF_FFF0, 8'h0F, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 5));
        vt.push_back(mk(MIN,  1'b1, 39'h1000, 64'h0000_0000_FFFF_FFFB, 64'h5,
                        64'hFFFF_FFFB_FFFF_FFFB, 8'h0F, 64'h5, 1'b0, 5));

        foreach (vt[i]) run_vec(vt[i]);

        // kill in LD_REQ while the D$ is not accepting: back to IDLE, nothing issued
        v = mk(OR_, 1'b0, 39'h5000, 64'h1, 64'h2, 64'h3, 8'hFF, 64'h2, 1'b0, 0);
        v.stall = 100;
        want_v = v; want_req = 1'b1; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = dc_req_valid;
        end
        chk("kill_ldreq_seen", 64'(found), 64'(1'b1));
        manual_kill = 1'b1;
        kill = 1'b1;
        tick();
        manual_kill = 1'b0;
        chk("kill_req_ready", 64'(req_ready), 64'(1'b1));
        chk("kill_busy", 64'(busy), 64'(1'b0));
        chk("kill_dc_valid", 64'(dc_req_valid), 64'(1'b0));
        sb.delete(); busy_txn = 1'b0; stall_cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            found = found | done_valid | dc_req_valid;
        end
        chk("kill_no_activity", 64'(found), 64'(1'b0));
        chk("kill_n_loads", 64'(n_ld), 64'(0));

        // Reset in ST_WAIT (store response withheld): immediate return to idle outputs
        v = mk(ADD, 1'b0, 39'h4000, 64'h1, 64'h2, 64'h3, 8'hFF, 64'h2, 1'b0, 0);
        no_st_resp = 1'b1;
        want_v = v; want_req = 1'b1;
        for (int i = 0; i < 20 && n_st == 0; i++) tick();
        chk("rst_seq_store", 64'(n_st), 64'(1));
        tick();
        chk("stwait_busy", 64'(busy), 64'(1'b1));
        chk("stwait_addr", 64'(dc_req_addr), 64'h4000);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'(1'b1));
        chk("arst_busy", 64'(busy), 64'(1'b0));
        chk("arst_dc_valid", 64'(dc_req_valid), 64'(1'b0));
        chk("arst_dc_addr", 64'(dc_req_addr), 64'h0);
        chk("arst_dc_mask", 64'(dc_req_mask), 64'h0);
        chk("arst_done_valid", 64'(done_valid), 64'(1'b0));
        pulse_reset();
        tick();

        // Recovery after reset
        run_vec(vt[0]);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
